// File: rtl/ram_fifo_controller.sv
// FIFO controller in front of a single-port 8x16 asynchronous RAM: one RAM access per
// WR/RD state, with a registered output word that extends capacity to DEPTH+1.
module ram_fifo_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_en,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   wptr_reg;
  logic [ADDR_W-1:0]   rptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic                out_valid_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [DATA_W-1:0]   wbuf_reg;
  logic                read_wanted;
  logic                push_take;

  assign count     = count_reg;
  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // A read is useful only if the output register is free or being drained this edge.
  assign read_wanted = !empty && (!out_valid_reg || out_ready);

  // RAM strobes depend only on state_reg and pointer registers, so they never glitch.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    push_take  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    case (state_reg)
      IDLE: begin
        in_ready = !full && !read_wanted;
        if (read_wanted) begin
          state_next = RD;
        end else if (in_valid && !full) begin
          state_next = WR;
          push_take  = 1'b1;
        end
      end
      WR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = wptr_reg;
        state_next = IDLE;
      end
      RD: begin
        ram_en     = 1'b1;
        ram_addr   = rptr_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_data = (state_reg == WR) ? wbuf_reg : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      wbuf_reg  <= '0;
    end else begin
      if (push_take) begin
        wbuf_reg <= in_data;
      end
      if (state_reg == WR) begin
        wptr_reg  <= wptr_reg + PTR_ONE;
        count_reg <= count_reg + COUNT_ONE;
      end else if (state_reg == RD) begin
        rptr_reg  <= rptr_reg + PTR_ONE;
        count_reg <= count_reg - COUNT_ONE;
      end
    end
  end

  // A completing read refills the output register even if it is consumed on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (state_reg == RD) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= ram_data;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule
